// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic matrix multiplier: C = A x B or C += A x B.
// Handles operand load handshake, input skewing, compute sequencing, done pulse and indexed readout.
module systolic_mm_engine #(
   parameter int unsigned N          = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = 64,
   parameter int unsigned SIGNED     = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic                         accum_i,
   input  logic [N*DATA_WIDTH-1:0]      a_col_i,
   input  logic [N*DATA_WIDTH-1:0]      b_row_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   output logic                         busy_o,
   output logic                         done_o,
   input  logic [$clog2(N*N):0]         res_idx_i,
   output logic [ACC_WIDTH-1:0]         res_o
);

   localparam int unsigned DW    = DATA_WIDTH;
   localparam int unsigned PW    = 2 * DATA_WIDTH;
   localparam int unsigned NN    = N * N;
   localparam int unsigned IDX_W = $clog2(N*N) + 1;
   localparam int unsigned CNT_W = $clog2(3*N);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 last_beat_c;
   logic                 last_cyc_c;

   logic [N*DW-1:0]      a_buf  [N];
   logic [N*DW-1:0]      b_buf  [N];
   logic [DW-1:0]        a_pipe [NN];
   logic [DW-1:0]        b_pipe [NN];
   logic [ACC_WIDTH-1:0] acc    [NN];

   logic [DW-1:0]        feed_a [N];
   logic [DW-1:0]        feed_b [N];
   logic [DW-1:0]        pe_a   [NN];
   logic [DW-1:0]        pe_b   [NN];
   logic [ACC_WIDTH-1:0] prod   [NN];

   // Full-width product, extended to the accumulator width according to SIGNED.
   function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [PW-1:0] ps;
      logic        [PW-1:0] pu;
      if (SIGNED != 0) begin
         ps = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
         return ACC_WIDTH'(ps);
      end else begin
         pu = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
         return ACC_WIDTH'(pu);
      end
   endfunction

   assign last_beat_c = (cnt_q == CNT_W'(N - 1));
   assign last_cyc_c  = (cnt_q == CNT_W'(3*N - 3));

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_i) state_d = S_LOAD;
         S_LOAD:    if (in_valid_i && last_beat_c) state_d = S_COMPUTE;
         S_COMPUTE: if (last_cyc_c) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State register and registered status outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         in_ready_o <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_o <= (state_d == S_LOAD);
         busy_o     <= (state_d != S_IDLE);
         done_o     <= (state_d == S_DONE);
      end
   end

   // Skewed edge feed: row i gets A[i][t-i], column j gets B[t-j][j], zero outside the window
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         feed_a[i] = '0;
         feed_b[i] = '0;
         for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(i + k)) begin
               feed_a[i] = a_buf[k][i*DW +: DW];
               feed_b[i] = b_buf[k][i*DW +: DW];
            end
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         localparam int unsigned P = gi*N + gj;
         if (gj == 0) begin : g_left_edge
            assign pe_a[P] = feed_a[gi];
         end else begin : g_left_int
            assign pe_a[P] = a_pipe[P-1];
         end
         if (gi == 0) begin : g_top_edge
            assign pe_b[P] = feed_b[gj];
         end else begin : g_top_int
            assign pe_b[P] = b_pipe[P-N];
         end
         assign prod[P] = mul_ext(pe_a[P], pe_b[P]);
      end
   end

   // Operand buffers, PE pipeline, accumulators and the shared beat/cycle counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         for (int unsigned k = 0; k < N; k++) begin
            a_buf[k] <= '0;
            b_buf[k] <= '0;
         end
         for (int unsigned p = 0; p < NN; p++) begin
            a_pipe[p] <= '0;
            b_pipe[p] <= '0;
            acc[p]    <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  cnt_q <= '0;
                  for (int unsigned p = 0; p < NN; p++) begin
                     a_pipe[p] <= '0;
                     b_pipe[p] <= '0;
                     if (!accum_i) acc[p] <= '0;
                  end
               end
            end
            S_LOAD: begin
               if (in_valid_i) begin
                  for (int unsigned k = 0; k < N; k++) begin
                     if (cnt_q == CNT_W'(k)) begin
                        a_buf[k] <= a_col_i;
                        b_buf[k] <= b_row_i;
                     end
                  end
                  cnt_q <= last_beat_c ? '0 : cnt_q + CNT_W'(1);
               end
            end
            S_COMPUTE: begin
               for (int unsigned p = 0; p < NN; p++) begin
                  acc[p]    <= acc[p] + prod[p];
                  a_pipe[p] <= pe_a[p];
                  b_pipe[p] <= pe_b[p];
               end
               cnt_q <= last_cyc_c ? '0 : cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Indexed readout; out-of-range indices read as zero
   always_comb begin
      res_o = '0;
      for (int unsigned k = 0; k < NN; k++) begin
         if (res_idx_i == IDX_W'(k)) res_o = acc[k];
      end
   end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: unsigned and signed instances run in lockstep
// against a plain matrix-arithmetic model, with randomized operands, gaps and accumulate mode.
module tb_systolic_mm_engine;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 64;
   localparam int IW = 5;
   localparam int NN = N * N;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          accum = 1'b0;
   logic          in_valid = 1'b0;
   logic [N*DW-1:0] a_col = '0;
   logic [N*DW-1:0] b_row = '0;
   logic [IW-1:0] res_idx = '0;
   logic          rdy_u, busy_u, done_u, rdy_s, busy_s, done_s;
   logic [AW-1:0] res_u, res_s;

   always #5 clk = ~clk;

   systolic_mm_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(0)) dut_u (
      .clk_i(clk), .rst_i(rst), .start_i(start), .accum_i(accum),
      .a_col_i(a_col), .b_row_i(b_row), .in_valid_i(in_valid),
      .in_ready_o(rdy_u), .busy_o(busy_u), .done_o(done_u),
      .res_idx_i(res_idx), .res_o(res_u));

   systolic_mm_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)) dut_s (
      .clk_i(clk), .rst_i(rst), .start_i(start), .accum_i(accum),
      .a_col_i(a_col), .b_row_i(b_row), .in_valid_i(in_valid),
      .in_ready_o(rdy_s), .busy_o(busy_s), .done_o(done_s),
      .res_idx_i(res_idx), .res_o(res_s));

   logic [DW-1:0] am [N][N];
   logic [DW-1:0] bm [N][N];
   logic [AW-1:0] cu [NN];
   logic [AW-1:0] cs [NN];
   int  checks = 0;
   int  errors = 0;
   bit  res_valid = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit s);
      longint        sa, sb;
      logic [AW-1:0] ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return AW'(sa * sb);
      end
      ua = AW'(a);
      ub = AW'(b);
      return ua * ub;
   endfunction

   task automatic model_run(input bit acc_mode);
      for (int p = 0; p < NN; p++) begin
         if (!acc_mode) begin
            cu[p] = '0;
            cs[p] = '0;
         end
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++) begin
               cu[i*N+j] = cu[i*N+j] + ref_mul(am[i][k], bm[k][j], 1'b0);
               cs[i*N+j] = cs[i*N+j] + ref_mul(am[i][k], bm[k][j], 1'b1);
            end
   endtask

   task automatic model_clear();
      for (int p = 0; p < NN; p++) begin
         cu[p] = '0;
         cs[p] = '0;
      end
   endtask

   // Result compare: whenever results are meaningful, res_o must match the model for the current index
   always @(negedge clk) begin
      int            idx;
      logic [AW-1:0] eu, es;
      if (res_valid) begin
         idx = int'(res_idx);
         eu  = '0;
         es  = '0;
         if (idx < NN) begin
            eu = cu[idx];
            es = cs[idx];
         end
         chk($sformatf("res_u[%0d]", idx), res_u, eu);
         chk($sformatf("res_s[%0d]", idx), res_s, es);
      end
   end

   task automatic sweep();
      res_valid = 1'b1;
      for (int idx = 0; idx <= NN; idx++) begin
         res_idx = IW'(idx);
         @(posedge clk); #1;
      end
   endtask

   task automatic lit(input int idx, input logic [63:0] eu, input logic [63:0] es);
      res_idx = IW'(idx);
      #1;
      chk($sformatf("lit_u[%0d]", idx), res_u, eu);
      chk($sformatf("lit_s[%0d]", idx), res_s, es);
   endtask

   task automatic drive_beat(input int k);
      for (int i = 0; i < N; i++) a_col[i*DW +: DW] = am[i][k];
      for (int j = 0; j < N; j++) b_row[j*DW +: DW] = bm[k][j];
   endtask

   // One run: start, N beats with optional gaps, wait for done; optional start pokes or mid-compute reset
   task automatic run(input bit acc_mode, input int gap, input bit poke, input int abort_at);
      int edges;
      bit seen;
      res_valid = 1'b0;
      start = 1'b1;
      accum = acc_mode;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", {62'd0, busy_u, busy_s}, 64'd3);
      chk("ready_in_load", {62'd0, rdy_u, rdy_s}, 64'd3);
      if (abort_at < 0) model_run(acc_mode);
      for (int k = 0; k < N; k++) begin
         drive_beat(k);
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (k < N-1) begin
            for (int g = 0; g < gap; g++) begin
               a_col = {$urandom, $urandom, $urandom, $urandom};
               b_row = {$urandom, $urandom, $urandom, $urandom};
               @(posedge clk); #1;
               chk("ready_in_gap", {62'd0, rdy_u, rdy_s}, 64'd3);
            end
         end
      end
      chk("ready_after_last", {62'd0, rdy_u, rdy_s}, 64'd0);
      chk("busy_in_compute", {62'd0, busy_u, busy_s}, 64'd3);
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 40) begin
         if (poke) start = (edges == 3);
         if (abort_at >= 0 && edges == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_busy", {62'd0, busy_u, busy_s}, 64'd0);
            chk("abort_ready", {62'd0, rdy_u, rdy_s}, 64'd0);
            chk("abort_done", {62'd0, done_u, done_s}, 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            model_clear();
            return;
         end
         @(posedge clk); #1;
         edges++;
         if (done_u) seen = 1'b1;
      end
      chk("done_latency", 64'(edges), 64'(3*N-2));
      chk("done_s_with_u", {63'd0, done_s}, 64'd1);
      if (poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_one_cycle", {62'd0, done_u, done_s}, 64'd0);
      chk("busy_drop", {62'd0, busy_u, busy_s}, 64'd0);
      @(posedge clk); #1;
      chk("idle_stays", {60'd0, busy_u, busy_s, rdy_u, rdy_s}, 64'd0);
      sweep();
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            if ($urandom_range(0, 1) == 0) begin
               am[i][j] = $urandom;
               bm[i][j] = $urandom;
            end else begin
               am[i][j] = DW'($urandom_range(0, 15)) - DW'(8);
               bm[i][j] = DW'($urandom_range(0, 15)) - DW'(8);
            end
         end
   endtask

   initial begin
      model_clear();
      #12;
      chk("rst_outputs", {58'd0, rdy_u, busy_u, done_u, rdy_s, busy_s, done_s}, 64'd0);
      lit(3, 64'd0, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_idle", {62'd0, busy_u, busy_s}, 64'd0);

      // Identity times a counting matrix
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            am[i][j] = (i == j) ? 32'd1 : 32'd0;
            bm[i][j] = 32'(i*N + j);
         end
      run(1'b0, 0, 1'b0, -1);
      lit(15, 64'd15, 64'd15);
      lit(6, 64'd6, 64'd6);
      lit(16, 64'd0, 64'd0);

      // Ones times twos, then accumulate the same product again
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            am[i][j] = 32'd1;
            bm[i][j] = 32'd2;
         end
      run(1'b0, 0, 1'b0, -1);
      lit(0, 64'd8, 64'd8);
      run(1'b1, 0, 1'b0, -1);
      lit(10, 64'd16, 64'd16);

      // All-ones bit pattern against ones: -4 signed, 4*(2^32-1) unsigned
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            am[i][j] = 32'hFFFF_FFFF;
            bm[i][j] = 32'd1;
         end
      run(1'b0, 0, 1'b0, -1);
      lit(7, 64'h3_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);

      // Identity run again with 3-cycle gaps between beats
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            am[i][j] = (i == j) ? 32'd1 : 32'd0;
            bm[i][j] = 32'(i*N + j);
         end
      run(1'b0, 3, 1'b0, -1);
      lit(9, 64'd9, 64'd9);

      // start_i poked in COMPUTE and in DONE must not launch a run
      rand_data();
      run(1'b0, 0, 1'b1, -1);
      repeat (3) @(posedge clk);
      #1;
      chk("no_rerun_busy", {62'd0, busy_u, busy_s}, 64'd0);
      sweep();

      // Reset at t=5 of COMPUTE, then a clean run
      rand_data();
      run(1'b0, 0, 1'b0, 5);
      sweep();
      lit(3, 64'd0, 64'd0);
      rand_data();
      run(1'b0, 0, 1'b0, -1);

      // Randomized runs with random accumulate mode and gaps
      for (int r = 0; r < 8; r++) begin
         rand_data();
         run(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, -1);
      end

      res_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
